// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS sequencing controller:
// state numbering, opcode values, ALU/mux select codes and the control bundle.
// Pure declarations; no logic.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every datapath control driven from the current state.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
  } ctl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore decode: current state (plus mem_ready in FETCH/MEMWR) to every control.
// Latency: purely combinational, no state.
// Handshake: mem_ready only gates the strobes that complete a memory access.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctl_t   o_ctl
);

  // Controls not named for a state stay 0; unused encodings drive nothing.
  always_comb begin
    o_ctl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctl.memread = 1'b1;
        o_ctl.alusrcb = SRCB_FOUR;
        o_ctl.irwrite = i_mem_ready;
        o_ctl.pcwrite = i_mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        o_ctl.alusrcb = SRCB_IMMSH;
      end
      S_MEMADR: begin
        o_ctl.alusrca = 1'b1;
        o_ctl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctl.memread = 1'b1;
        o_ctl.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_ctl.regwrite   = 1'b1;
        o_ctl.memtoreg   = 1'b1;
        o_ctl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe held for the whole wait; done only on the accepting cycle.
        o_ctl.memwrite   = 1'b1;
        o_ctl.iord       = 1'b1;
        o_ctl.instr_done = i_mem_ready;
      end
      S_EXEC: begin
        o_ctl.alusrca = 1'b1;
        o_ctl.alusrcb = SRCB_B;
        o_ctl.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        o_ctl.regwrite   = 1'b1;
        o_ctl.regdst     = 1'b1;
        o_ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctl.alusrca     = 1'b1;
        o_ctl.alusrcb     = SRCB_B;
        o_ctl.aluop       = ALUOP_SUB;
        o_ctl.pcwritecond = 1'b1;
        o_ctl.pcsource    = PCSRC_ALUOUT;
        o_ctl.instr_done  = 1'b1;
      end
      S_JUMP: begin
        o_ctl.pcwrite    = 1'b1;
        o_ctl.pcsource   = PCSRC_JUMP;
        o_ctl.instr_done = 1'b1;
      end
      default: begin
        o_ctl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: steps fetch/decode/execute/memory/writeback.
// Latency: outputs follow the state register combinationally; one state per clk.
// Stalls in FETCH, MEMRD and MEMWR until mem_ready; strobes forced 0 in reset.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Op,
  input  logic               mem_ready,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state
);

  state_t r_state;
  state_t w_next;
  ctl_t   w_ctl;
  logic   w_unused_zero;

  // The branch decision is taken in the datapath from PCWriteCond & Zero.
  assign w_unused_zero = Zero;

  // Next-state selection; Op is only consulted in DECODE and MEMADR.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_LW)      w_next = S_MEMRD;
        else if (Op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  mc_output_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctl       (w_ctl)
  );

  // Strobes are qualified by rst_n so nothing writes while reset is held;
  // selects are left alone and show their FETCH values.
  assign PCWrite     = w_ctl.pcwrite     & rst_n;
  assign PCWriteCond = w_ctl.pcwritecond & rst_n;
  assign MemRead     = w_ctl.memread     & rst_n;
  assign MemWrite    = w_ctl.memwrite    & rst_n;
  assign IRWrite     = w_ctl.irwrite     & rst_n;
  assign RegWrite    = w_ctl.regwrite    & rst_n;
  assign instr_done  = w_ctl.instr_done  & rst_n;
  assign illegal_op  = rst_n & (r_state == S_DECODE) & ~is_supported(Op);

  assign IorD     = w_ctl.iord;
  assign MemtoReg = w_ctl.memtoreg;
  assign RegDst   = w_ctl.regdst;
  assign ALUSrcA  = w_ctl.alusrca;
  assign ALUSrcB  = w_ctl.alusrcb;
  assign ALUOp    = w_ctl.aluop;
  assign PCSource = w_ctl.pcsource;
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed then randomized instruction streams
// checked against an instruction-level reference (state path, controls, cycle count).
module tb_multicycle_control;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
  } tctl_t;

  localparam logic [5:0] T_R   = 6'b000000;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100;
  localparam logic [5:0] T_J   = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = '0;
  logic       mem_ready = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  multicycle_control #(.OP_W(6), .ALUOP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  tctl_t obs;
  always_comb begin
    obs = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
            illegal_op};
  end

  function automatic bit legal(input logic [5:0] op);
    return op inside {T_R, T_LW, T_SW, T_BEQ, T_J};
  endfunction

  // Expected controls for each step of an instruction, straight from the state table.
  function automatic tctl_t exp_ctl(input int st, input bit mr, input logic [5:0] op);
    tctl_t c;
    c = '0;
    case (st)
      0: begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = mr; c.PCWrite = mr; end
      1: begin c.ALUSrcB = 2'b11; c.illegal_op = !legal(op); end
      2: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
      3: begin c.MemRead = 1; c.IorD = 1; end
      4: begin c.RegWrite = 1; c.MemtoReg = 1; c.instr_done = 1; end
      5: begin c.MemWrite = 1; c.IorD = 1; c.instr_done = mr; end
      6: begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
      7: begin c.RegWrite = 1; c.RegDst = 1; c.instr_done = 1; end
      8: begin c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCWriteCond = 1; c.PCSource = 2'b01;
               c.instr_done = 1; end
      9: begin c.PCWrite = 1; c.PCSource = 2'b10; c.instr_done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // In reset: FETCH selects, every strobe low.
  function automatic tctl_t rst_ctl();
    tctl_t c;
    c = '0;
    c.ALUSrcB = 2'b01;
    return c;
  endfunction

  task automatic chk_state(input int exp, input string tag);
    checks++;
    assert (state === exp[3:0]) else begin
      failures++;
      $error("FAIL %s state got=%0d exp=%0d", tag, state, exp);
    end
  endtask

  task automatic chk_ctl(input tctl_t exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ctl got=%b exp=%b (state=%0d)", tag, obs, exp, state);
    end
  endtask

  task automatic chk_int(input int got, input int exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check 1ns later.
  task automatic do_cycle(input int st, input bit mr, input logic [5:0] op,
                          input string tag, output bit d, output bit il);
    @(negedge clk);
    mem_ready = mr;
    Op = (st == 0) ? 6'($urandom) : op;   // opcode is meaningless before DECODE
    Zero = 1'($urandom);
    #1;
    chk_state(st, tag);
    chk_ctl(exp_ctl(st, mr, Op), tag);
    d = instr_done;
    il = illegal_op;
  endtask

  // Instruction-level reference: build the state walk, then check the
  // done/illegal pulses and the cycle count against the nominal latencies.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input string tag);
    int st_q[$];
    bit mr_q[$];
    int base, waits, n_done, n_ill, end_at;
    bit d, il;
    for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(0); end
    st_q.push_back(0); mr_q.push_back(1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    waits = fw;
    case (op)
      T_LW: begin
        base = 5; waits += mw;
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin st_q.push_back(3); mr_q.push_back(0); end
        st_q.push_back(3); mr_q.push_back(1);
        st_q.push_back(4); mr_q.push_back(1'($urandom));
      end
      T_SW: begin
        base = 4; waits += mw;
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin st_q.push_back(5); mr_q.push_back(0); end
        st_q.push_back(5); mr_q.push_back(1);
      end
      T_R: begin
        base = 4;
        st_q.push_back(6); mr_q.push_back(1'($urandom));
        st_q.push_back(7); mr_q.push_back(1'($urandom));
      end
      T_BEQ: begin base = 3; st_q.push_back(8); mr_q.push_back(1'($urandom)); end
      T_J:   begin base = 3; st_q.push_back(9); mr_q.push_back(1'($urandom)); end
      default: base = 2;
    endcase
    n_done = 0; n_ill = 0; end_at = -1;
    foreach (st_q[i]) begin
      do_cycle(st_q[i], mr_q[i], op, tag, d, il);
      n_done += int'(d);
      n_ill  += int'(il);
      if (d || il) end_at = i + 1;
    end
    chk_int(n_done, legal(op) ? 1 : 0, {tag, "_done_pulses"});
    chk_int(n_ill, legal(op) ? 0 : 1, {tag, "_illegal_pulses"});
    chk_int(end_at, base + waits, {tag, "_cycles"});
  endtask

  initial begin
    bit d, il;
    logic [5:0] op;
    int kind;

    // Reset held 3 cycles with mem_ready=1.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk_state(0, "reset");
      chk_ctl(rst_ctl(), "reset");
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Directed instructions.
    run_instr(T_LW, 0, 0, "lw");
    run_instr(T_SW, 0, 2, "sw_wait");
    run_instr(T_R, 0, 0, "rtype");
    run_instr(T_BEQ, 0, 0, "beq");
    run_instr(T_J, 0, 0, "jump");
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(T_LW, 2, 1, "lw_waits");

    // Randomized instruction mix with random memory stalls.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: op = T_R;
        1: op = T_LW;
        2: op = T_SW;
        3: op = T_BEQ;
        4: op = T_J;
        default: begin
          op = 6'($urandom);
          while (legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rand");
    end

    // Reset while waiting in MEMRD.
    do_cycle(0, 1'b1, T_LW, "mid_fetch", d, il);
    do_cycle(1, 1'b1, T_LW, "mid_decode", d, il);
    do_cycle(2, 1'b1, T_LW, "mid_memadr", d, il);
    do_cycle(3, 1'b0, T_LW, "mid_memrd", d, il);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk_state(0, "mid_reset_async");
    chk_ctl(rst_ctl(), "mid_reset_async");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk_state(0, "mid_reset_hold");
      chk_ctl(rst_ctl(), "mid_reset_hold");
    end
    @(posedge clk); #2 rst_n = 1'b1;
    run_instr(T_LW, 0, 0, "post_reset_lw");
    run_instr(T_BEQ, 1, 0, "post_reset_beq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing controller for the multicycle MIPS datapath. It replaces the single-cycle opcode decoder when the datapath shares one memory, one ALU and the IR/A/B/ALUOut registers across cycles.
- A Moore-style FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write strobe.
- It waits on a memory-ready handshake and flags unsupported opcodes.
- Supported opcodes: R-format, lw, sw, beq, j.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 2, ALU-control encoding width (00 add, 01 sub, 10 funct-decode).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Op  in  OP_W  opcode from IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- Zero  in  1  ALU zero flag
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if Zero (beq)
- IorD  out  1  memory address select, 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback data select, 1=MDR
- RegDst  out  1  destination register select, 1=rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=4, 10=sign-extended imm, 11=imm<<2
- ALUOp  out  ALUOP_W  to ALU control
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug and verification

Behaviour:
Reset:
- rst_n low forces state=FETCH asynchronously.
- While rst_n=0, all strobes are forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal_op.
- Select outputs hold their FETCH values during reset.
- The first FETCH is the first rising edge after rst_n deasserts.
- Reset mid-instruction abandons that instruction; no partial writes occur after the reset edge.

States (4-bit encoding) and transitions:
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - lw or sw -> MEMADR
  - R-format -> EXEC
  - beq -> BRANCH
  - j -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 this cycle
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD(3): MemRead=1, IorD=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. -> FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Holds until mem_ready=1; on that cycle instr_done=1, then -> FETCH. MemWrite stays high for the whole hold.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RWB.
- RWB(7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. -> FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. -> FETCH.
- JUMP(9): PCWrite=1, PCSource=10, instr_done=1. -> FETCH.
- Encodings 10-15 are unreachable; if entered, they go to FETCH with all strobes 0.

Output and timing rules:
- Any output not listed for a state is 0.
- Outputs are combinational from state (plus mem_ready where stated). No glitch-sensitive use is allowed outside clk.
- Cycle counts with mem_ready tied to 1: R=4, lw=5, sw=4, beq=3, j=3, illegal=2. Each wait cycle at FETCH, MEMRD or MEMWR adds one.
- Op is sampled only in DECODE and MEMADR. It must be stable (IR held) from DECODE through completion.

Decomposition:
- Package mc_pkg holds:
  - state enum, 4-bit
  - opcode constants: OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_J=000010
  - ALUOp codes and PCSource/ALUSrcB codes
- The state register and next-state logic live in multicycle_control.
- The pure state-to-control decode is one natural sub-module: mc_output_decode (inputs state, mem_ready; outputs all controls).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> state=0, all strobes 0; first post-reset cycle shows MemRead=1, IRWrite=1, PCWrite=1.
- lw: Op=100011, mem_ready=1 -> states 0,1,2,3,4 over 5 cycles; RegWrite=1, MemtoReg=1 only in state 4; instr_done pulses once.
- sw with wait: Op=101011, mem_ready low 2 cycles in MEMWR -> MemWrite high for 3 cycles, instr_done on the third, total 6 cycles.
- R-format then beq: Op=000000 -> states 0,1,6,7 with RegDst=1 in RWB. Next Op=000100 -> states 0,1,8 with PCWriteCond=1, ALUOp=01, PCSource=01.
- j and illegal: Op=000010 -> states 0,1,9 with PCWrite=1, PCSource=10. Op=111111 -> states 0,1,0, illegal_op=1 in DECODE, no RegWrite/MemWrite.
- Reset mid-MEMRD: rst_n low while in state 3 -> state=0 immediately, MemRead forced 0, no RegWrite on the following cycles.
